// File: rtl/llc_req_driver.sv
// rtl/llc_req_driver.sv - LLC request driver: command FIFO, fixed-latency LLC access FSM, responses and statistics
module llc_req_driver #(
  parameter int FIFO_DEPTH = 8,
  parameter int RESP_LAT   = 1,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_wr,
  input  logic [31:0]      cmd_addr,
  input  logic [7:0]       cmd_data,
  output logic             llc_cs,
  output logic             llc_wr,
  output logic [31:0]      llc_addr,
  output logic [7:0]       llc_data_in,
  input  logic             llc_hit,
  input  logic [7:0]       llc_data_out,
  output logic             rsp_valid,
  output logic             rsp_wr,
  output logic [31:0]      rsp_addr,
  output logic             rsp_hit,
  output logic [7:0]       rsp_data,
  input  logic             stat_clr,
  output logic [CNT_W-1:0] rd_cnt,
  output logic [CNT_W-1:0] wr_cnt,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt,
  output logic             busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  // WAIT covers RESP_LAT-1 cycles, so the down-counter starts at RESP_LAT-2
  localparam int LW = (RESP_LAT > 2) ? $clog2(RESP_LAT) : 1;
  localparam logic [LW-1:0] WAIT_INIT = (RESP_LAT > 2) ? LW'(RESP_LAT - 2) : '0;
  localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_CAPTURE} state_t;

  state_t state_q, state_d;

  logic          fifo_wr_mem   [FIFO_DEPTH];
  logic [31:0]   fifo_addr_mem [FIFO_DEPTH];
  logic [7:0]    fifo_data_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   fifo_cnt_q;
  logic          fifo_push, fifo_pop, fifo_empty;

  logic [LW-1:0] wait_cnt_q;
  logic          capture_en;

  // last issued command: drives the held LLC port and tags the in-flight response
  logic          last_wr_q;
  logic [31:0]   last_addr_q;
  logic [7:0]    last_data_q;

  logic             rsp_valid_q, rsp_wr_q, rsp_hit_q;
  logic [31:0]      rsp_addr_q;
  logic [7:0]       rsp_data_q;
  logic [CNT_W-1:0] rd_cnt_q, wr_cnt_q, hit_cnt_q, miss_cnt_q;

  assign fifo_empty = (fifo_cnt_q == '0);
  assign cmd_ready  = (fifo_cnt_q != FULL_CNT);
  assign fifo_push  = cmd_valid && cmd_ready;
  assign busy       = !fifo_empty || (state_q != S_IDLE);

  // command storage; contents need no reset since occupancy gates every read
  always_ff @(posedge clk) begin
    if (fifo_push) begin
      fifo_wr_mem[wr_ptr_q]   <= cmd_wr;
      fifo_addr_mem[wr_ptr_q] <= cmd_addr;
      fifo_data_mem[wr_ptr_q] <= cmd_data;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (fifo_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (fifo_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({fifo_push, fifo_pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + (AW + 1)'(1);
        2'b01:   fifo_cnt_q <= fifo_cnt_q - (AW + 1)'(1);
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (!fifo_empty) state_d = S_ISSUE;
      S_ISSUE:   state_d = (RESP_LAT > 1) ? S_WAIT : S_CAPTURE;
      S_WAIT:    if (wait_cnt_q == '0) state_d = S_CAPTURE;
      S_CAPTURE: state_d = fifo_empty ? S_IDLE : S_ISSUE;
      default:   state_d = S_IDLE;
    endcase
  end

  // FSM outputs: LLC strobe, FIFO pop and capture enable; port shows the head while issuing
  always_comb begin
    llc_cs      = 1'b0;
    fifo_pop    = 1'b0;
    capture_en  = 1'b0;
    llc_wr      = last_wr_q;
    llc_addr    = last_addr_q;
    llc_data_in = last_data_q;
    case (state_q)
      S_ISSUE: begin
        llc_cs      = 1'b1;
        fifo_pop    = 1'b1;
        llc_wr      = fifo_wr_mem[rd_ptr_q];
        llc_addr    = fifo_addr_mem[rd_ptr_q];
        llc_data_in = fifo_data_mem[rd_ptr_q];
      end
      S_CAPTURE: capture_en = 1'b1;
      default: ;
    endcase
  end

  // remember the issued command so the port holds it after cs drops
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_wr_q   <= 1'b0;
      last_addr_q <= '0;
      last_data_q <= '0;
    end else if (fifo_pop) begin
      last_wr_q   <= fifo_wr_mem[rd_ptr_q];
      last_addr_q <= fifo_addr_mem[rd_ptr_q];
      last_data_q <= fifo_data_mem[rd_ptr_q];
    end
  end

  // latency down-counter, loaded while issuing and run through WAIT
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt_q <= '0;
    end else if (state_q == S_ISSUE) begin
      wait_cnt_q <= WAIT_INIT;
    end else if (state_q == S_WAIT && wait_cnt_q != '0) begin
      wait_cnt_q <= wait_cnt_q - LW'(1);
    end
  end

  // response register: one-cycle valid pulse, payload held until the next response
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid_q <= 1'b0;
      rsp_wr_q    <= 1'b0;
      rsp_addr_q  <= '0;
      rsp_hit_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= capture_en;
      if (capture_en) begin
        rsp_wr_q   <= last_wr_q;
        rsp_addr_q <= last_addr_q;
        rsp_hit_q  <= llc_hit;
        rsp_data_q <= last_wr_q ? 8'h00 : llc_data_out;
      end
    end
  end

  // saturating statistics; a clear wins over a same-cycle increment
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (stat_clr) begin
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (rsp_valid_q) begin
      if (rsp_wr_q) begin
        if (wr_cnt_q != '1) wr_cnt_q <= wr_cnt_q + CNT_W'(1);
      end else begin
        if (rd_cnt_q != '1) rd_cnt_q <= rd_cnt_q + CNT_W'(1);
      end
      if (rsp_hit_q) begin
        if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + CNT_W'(1);
      end else begin
        if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + CNT_W'(1);
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_wr    = rsp_wr_q;
  assign rsp_addr  = rsp_addr_q;
  assign rsp_hit   = rsp_hit_q;
  assign rsp_data  = rsp_data_q;
  assign rd_cnt    = rd_cnt_q;
  assign wr_cnt    = wr_cnt_q;
  assign hit_cnt   = hit_cnt_q;
  assign miss_cnt  = miss_cnt_q;

endmodule
